// File: rtl/iob2axi_ctrl_pkg.sv
// Shared definitions for the iob2axi transfer sequencer.
//   - FSM state encoding (plain localparams so legacy code can compare against them)
//   - byte_shift(): log2 of the byte-lane count for a given word width
package iob2axi_ctrl_pkg;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StLaunch = 3'd1;
    localparam logic [2:0] StXfer   = 3'd2;
    localparam logic [2:0] StDrain  = 3'd3;
    localparam logic [2:0] StDone   = 3'd4;

    // Shift that turns a word index into a byte offset.
    function automatic int unsigned byte_shift(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/iob2axi_ctrl_buf.sv
// Single-entry read-data buffer between iob2axi's native port and the output stream.
//   load : capture din (wins over pop, so load+pop in one cycle keeps the buffer full)
//   pop  : consumer took the current word
//   full : buffer holds a word; dout is that word
module iob2axi_ctrl_buf #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic              full,
    output logic [DATA_W-1:0] dout
);

    logic              full_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            if (load) begin
                data_q <= din;
                full_q <= 1'b1;
            end else if (pop) begin
                full_q <= 1'b0;
            end
        end
    end

    assign full = full_q;
    assign dout = data_q;

endmodule

// File: rtl/iob2axi_ctrl.sv
// Transfer sequencer in front of iob2axi.
// Takes a descriptor (dir/addr/len) on start, pulses c_run once iob2axi is ready, then moves
// exactly len words over iob2axi's native slave port.
//   CPU side   : start, dir, addr, len -> busy, done (pulse), error (sticky)
//   write data : in_valid/in_data/in_ready stream feeding m_wdata
//   read data  : out_valid/out_data/out_ready stream fed from m_rdata via a one-word buffer
//   iob2axi    : c_run/c_direction/c_addr/c_ready/c_error control, m_* native request port
module iob2axi_ctrl
    import iob2axi_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned LEN_W     = 16,
    parameter int unsigned DRAIN_CYC = 260
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                dir,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [LEN_W-1:0]    len,
    output logic                busy,
    output logic                done,
    output logic                error,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    output logic                in_ready,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    input  logic                out_ready,
    output logic                c_run,
    output logic                c_direction,
    output logic [ADDR_W-1:0]   c_addr,
    input  logic                c_ready,
    input  logic                c_error,
    output logic                m_valid,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_ready
);

    localparam int unsigned STRB_W     = DATA_W / 8;
    localparam int unsigned BYTE_SHIFT = byte_shift(DATA_W);
    localparam int unsigned DRAIN_W    = $clog2(DRAIN_CYC + 1);

    logic [2:0]         state_q, state_d;
    logic               dir_q, dir_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   idx_q, idx_d;   // words requested/accepted on the native port
    logic [LEN_W-1:0]   pop_q, pop_d;   // words delivered on the read stream
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               error_q, error_d;

    logic xfer_wr, xfer_rd, m_hs, buf_full, buf_pop, buf_load;

    iob2axi_ctrl_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk  (clk),
        .rst  (rst),
        .load (buf_load),
        .pop  (buf_pop),
        .din  (m_rdata),
        .full (buf_full),
        .dout (out_data)
    );

    always_comb begin
        xfer_wr  = (state_q == StXfer) && dir_q;
        xfer_rd  = (state_q == StXfer) && !dir_q;
        busy     = (state_q != StIdle);
        done     = (state_q == StDone);
        error    = error_q;

        out_valid = buf_full;
        buf_pop   = buf_full && out_ready;

        // Read side may re-request in the same cycle the held word leaves.
        if (xfer_wr) begin
            m_valid = in_valid;
        end else if (xfer_rd) begin
            m_valid = (idx_q < len_q) && (!buf_full || buf_pop);
        end else begin
            m_valid = 1'b0;
        end
        m_hs     = m_valid && m_ready;
        buf_load = xfer_rd && m_hs;

        in_ready = xfer_wr && m_ready;
        m_wdata  = xfer_wr ? in_data : '0;
        m_wstrb  = xfer_wr ? {STRB_W{1'b1}} : '0;
        m_addr   = busy ? addr_q + (ADDR_W'(idx_q) << BYTE_SHIFT) : '0;

        c_run       = (state_q == StLaunch) && c_ready;
        c_direction = 1'b0;
        c_addr      = '0;
        if (state_q == StLaunch || state_q == StXfer || state_q == StDrain) begin
            c_direction = dir_q;
            c_addr      = addr_q;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        addr_d  = addr_q;
        len_d   = len_q;
        idx_d   = idx_q;
        pop_d   = pop_q;
        drain_d = drain_q;
        error_d = error_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    dir_d   = dir;
                    addr_d  = addr;
                    len_d   = len;
                    idx_d   = '0;
                    pop_d   = '0;
                    drain_d = '0;
                    error_d = 1'b0;
                    state_d = (len == '0) ? StDone : StLaunch;
                end
            end
            StLaunch: begin
                if (c_ready) state_d = StXfer;
            end
            StXfer: begin
                if (m_hs) idx_d = idx_q + LEN_W'(1);
                if (dir_q) begin
                    if (m_hs && idx_q == len_q - LEN_W'(1)) begin
                        drain_d = '0;
                        state_d = StDrain;
                    end
                end else if (buf_pop) begin
                    pop_d = pop_q + LEN_W'(1);
                    if (pop_q == len_q - LEN_W'(1)) state_d = StDone;
                end
            end
            StDrain: begin
                // Only an unbroken run of c_ready proves iob2axi's write FIFO is empty.
                if (c_ready) begin
                    if (drain_q == DRAIN_W'(DRAIN_CYC - 1)) begin
                        state_d = StDone;
                    end else begin
                        drain_d = drain_q + DRAIN_W'(1);
                    end
                end else begin
                    drain_d = '0;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (state_q != StIdle && c_error) error_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            dir_q   <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            pop_q   <= '0;
            drain_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            pop_q   <= pop_d;
            drain_q <= drain_d;
            error_q <= error_d;
        end
    end

endmodule

// File: tb/tb_iob2axi_ctrl.sv
// Self-checking bench for iob2axi_ctrl: a simple iob2axi slave model, a write-data source,
// a read-data sink, and scoreboards of expected native-port and stream traffic.
module tb_iob2axi_ctrl;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned LEN_W     = 16;
    localparam int unsigned DRAIN_CYC = 260;

    logic              clk, rst;
    logic              start, dir;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic              busy, done, error;
    logic              in_valid, in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid, out_ready;
    logic [DATA_W-1:0] out_data;
    logic              c_run, c_direction, c_ready, c_error;
    logic [ADDR_W-1:0] c_addr;
    logic              m_valid, m_ready;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata, m_rdata;
    logic [3:0]        m_wstrb;

    iob2axi_ctrl #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .LEN_W     (LEN_W),
        .DRAIN_CYC (DRAIN_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dir         (dir),
        .addr        (addr),
        .len         (len),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .c_run       (c_run),
        .c_direction (c_direction),
        .c_addr      (c_addr),
        .c_ready     (c_ready),
        .c_error     (c_error),
        .m_valid     (m_valid),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_wstrb     (m_wstrb),
        .m_rdata     (m_rdata),
        .m_ready     (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    // Scoreboards
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] rd_addr_q[$];
    logic [31:0] rd_data_q[$];
    logic [31:0] wr_src[$];

    int          wr_src_idx = 0;
    logic        cur_dir = 1'b0;
    int          cur_len = 0;
    logic [31:0] exp_c_addr = '0;
    bit          ready_rand = 0;
    bit          or_toggle  = 0;

    int   cyc = 0, n_run = 0, n_done = 0, n_words = 0, n_pops = 0;
    int   done_cyc = 0, last_word_cyc = 0, last_pop_cyc = 0, start_cyc = 0;
    logic err_at_done = 1'b0;

    // Slave model and stream drivers: update just after the falling edge.
    always @(negedge clk) begin
        #1;
        m_ready   = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        m_rdata   = $urandom;
        out_ready = or_toggle ? ~out_ready : 1'b1;
        in_valid  = (wr_src_idx < wr_src.size());
        in_data   = in_valid ? wr_src[wr_src_idx] : '0;
    end

    // Monitor: samples mid-low-phase, well away from the rising edge.
    always @(negedge clk) begin
        #3;
        if (!rst) begin
            cyc++;
            if (c_run) begin
                n_run++;
                check_eq("c_run_addr", c_addr, exp_c_addr);
                check_eq("c_run_dir", c_direction, cur_dir);
            end
            if (done) begin
                n_done++;
                done_cyc    = cyc;
                err_at_done = error;
            end
            if (m_valid && m_ready) begin
                if (cur_dir) begin
                    if (wr_addr_q.size() == 0) begin
                        check_eq("wr_extra_word", m_valid, 0);
                    end else begin
                        check_eq("wr_addr", m_addr, wr_addr_q.pop_front());
                        check_eq("wr_data", m_wdata, wr_data_q.pop_front());
                        check_eq("wr_strb", m_wstrb, 4'hF);
                    end
                    wr_src_idx++;
                    n_words++;
                    last_word_cyc = cyc;
                end else begin
                    if (rd_addr_q.size() == 0) begin
                        check_eq("rd_extra_req", m_valid, 0);
                    end else begin
                        check_eq("rd_addr", m_addr, rd_addr_q.pop_front());
                        check_eq("rd_strb", m_wstrb, 4'h0);
                    end
                    rd_data_q.push_back(m_rdata);
                end
            end
            if (out_valid && out_ready) begin
                if (rd_data_q.size() == 0) begin
                    check_eq("rd_extra_pop", out_valid, 0);
                end else begin
                    check_eq("rd_data", out_data, rd_data_q.pop_front());
                end
                n_pops++;
                if (n_pops == cur_len) last_pop_cyc = cyc;
            end
        end
    end

    task automatic launch(input logic d, input logic [31:0] a, input int l);
        @(negedge clk);
        start = 1'b1;
        dir   = d;
        addr  = a;
        len   = LEN_W'(l);
        #4 start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, input string tag);
        int k;
        k = 0;
        while (n_done == d0 && k < budget) begin
            @(negedge clk);
            #4;
            k++;
        end
        check_eq(tag, n_done - d0, 1);
    endtask

    int run0, done0;

    initial begin
        rst = 1'b1; start = 1'b0; dir = 1'b0; addr = '0; len = '0;
        c_ready = 1'b1; c_error = 1'b0; m_ready = 1'b0; m_rdata = '0;
        out_ready = 1'b0; in_valid = 1'b0; in_data = '0;

        repeat (3) @(negedge clk);
        #4;
        check_eq("reset_busy", busy, 0);
        check_eq("reset_outs", |{done, error, in_ready, out_valid, out_data, c_run, c_direction,
                                 c_addr, m_valid, m_addr, m_wdata, m_wstrb}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Write len=4 at 0x1000, no stalls
        cur_dir = 1'b1; exp_c_addr = 32'h1000; n_words = 0;
        for (int i = 0; i < 4; i++) begin
            wr_addr_q.push_back(32'h1000 + 32'(4 * i));
            wr_data_q.push_back(32'(i + 1));
            wr_src.push_back(32'(i + 1));
        end
        run0 = n_run; done0 = n_done;
        launch(1'b1, 32'h1000, 4);
        wait_done(done0, 600, "wr4_done");
        check_eq("wr4_runs", n_run - run0, 1);
        check_eq("wr4_words", n_words, 4);
        check_eq("wr4_leftover", wr_addr_q.size(), 0);
        // 260 quiet drain cycles after the last word, then DONE is seen one sample later
        check_eq("wr4_drain_lat", done_cyc - last_word_cyc, DRAIN_CYC + 1);
        check_eq("wr4_error", err_at_done, 0);

        // Read len=3 at 0x2000, random m_ready, toggling out_ready
        cur_dir = 1'b0; cur_len = 3; n_pops = 0; exp_c_addr = 32'h2000;
        ready_rand = 1; or_toggle = 1;
        for (int i = 0; i < 3; i++) rd_addr_q.push_back(32'h2000 + 32'(4 * i));
        run0 = n_run; done0 = n_done;
        launch(1'b0, 32'h2000, 3);
        wait_done(done0, 200, "rd3_done");
        check_eq("rd3_runs", n_run - run0, 1);
        check_eq("rd3_pops", n_pops, 3);
        check_eq("rd3_leftover", rd_data_q.size(), 0);
        check_eq("rd3_done_at_pop", done_cyc - last_pop_cyc, 1);
        ready_rand = 0; or_toggle = 0;

        // Write len=8 with a c_error pulse and a start while busy
        cur_dir = 1'b1; exp_c_addr = 32'h3000; n_words = 0;
        wr_src.delete(); wr_src_idx = 0;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] w;
            w = $urandom;
            wr_addr_q.push_back(32'h3000 + 32'(4 * i));
            wr_data_q.push_back(w);
            wr_src.push_back(w);
        end
        run0 = n_run; done0 = n_done;
        launch(1'b1, 32'h3000, 8);
        for (int k = 0; k < 100 && n_words < 3; k++) begin
            @(negedge clk);
            #4;
        end
        @(negedge clk);
        c_error = 1'b1; start = 1'b1; dir = 1'b0; addr = 32'hDEAD0; len = 1;
        @(negedge clk);
        c_error = 1'b0; start = 1'b0;
        #4;
        check_eq("busy_start_caddr", c_addr, 32'h3000);
        check_eq("busy_start_cdir", c_direction, 1);
        wait_done(done0, 800, "wr8_done");
        check_eq("wr8_runs", n_run - run0, 1);
        check_eq("wr8_words", n_words, 8);
        check_eq("wr8_err_at_done", err_at_done, 1);
        repeat (5) @(negedge clk);
        #4;
        check_eq("err_sticky", error, 1);

        // len=0: straight to done, no c_run, error cleared by the accepted start
        run0 = n_run; done0 = n_done;
        launch(1'b1, 32'h0, 0);
        #4;
        check_eq("len0_err_clr", error, 0);
        wait_done(done0, 10, "len0_done");
        check_eq("len0_lat_ok", (done_cyc - start_cyc >= 1) && (done_cyc - start_cyc <= 2), 1);
        check_eq("len0_no_run", n_run - run0, 0);

        // Reset during a read of 5, after the first word pops
        cur_dir = 1'b0; cur_len = 5; n_pops = 0; exp_c_addr = 32'h4000;
        for (int i = 0; i < 5; i++) rd_addr_q.push_back(32'h4000 + 32'(4 * i));
        launch(1'b0, 32'h4000, 5);
        for (int k = 0; k < 100 && n_pops < 1; k++) begin
            @(negedge clk);
            #4;
        end
        check_eq("rst_mid_progress", n_pops >= 1, 1);
        done0 = n_done;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_busy", busy, 0);
        check_eq("rst_mid_outs", |{done, error, in_ready, out_valid, out_data, c_run,
                                   c_direction, c_addr, m_valid, m_addr, m_wdata, m_wstrb}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd_addr_q.delete(); rd_data_q.delete();
        repeat (2) @(negedge clk);
        #4;
        check_eq("rst_mid_no_done", n_done - done0, 0);

        // Fresh read after the abort
        cur_len = 2; n_pops = 0; exp_c_addr = 32'h5000;
        for (int i = 0; i < 2; i++) rd_addr_q.push_back(32'h5000 + 32'(4 * i));
        done0 = n_done;
        launch(1'b0, 32'h5000, 2);
        wait_done(done0, 100, "rd2_done");
        check_eq("rd2_pops", n_pops, 2);
        check_eq("rd2_leftover", rd_data_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
